// File: rtl/uart_rx_deser_if.sv
// Serial-line and received-word bundle for uart_rx_deser.
// slave = the receiver, master = the side driving the line and reading results.
interface uart_rx_deser_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  RX_IN_S;
    logic [5:0]            Prescale;
    logic                  parity_enable;
    logic                  parity_type;
    logic [DATA_WIDTH-1:0] RX_OUT_P;
    logic                  RX_OUT_V;
    logic                  parity_error;
    logic                  framing_error;

    modport master (
        output RX_IN_S, Prescale, parity_enable, parity_type,
        input  RX_OUT_P, RX_OUT_V, parity_error, framing_error
    );

    modport slave (
        input  RX_IN_S, Prescale, parity_enable, parity_type,
        output RX_OUT_P, RX_OUT_V, parity_error, framing_error
    );
endinterface

// File: rtl/uart_rx_deser.sv
// Oversampling UART receiver: 2-of-3 mid-bit majority, optional parity, one-cycle result pulses.
// Optional feature: define UART_RX_SYNC_EN to add a two-flop input synchronizer (+2 cycles latency).
module uart_rx_deser #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic            RX_CLK,
    input  logic            RST,
    uart_rx_deser_if.slave  bus
);
    localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int unsigned EDGE_W    = 6;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [EDGE_W-1:0]       edge_q, edge_d;
    logic [EDGE_W-1:0]       presc_q, presc_d;
    logic [BIT_CNT_W-1:0]    bit_q, bit_d;
    logic                    par_en_q, par_en_d;
    logic                    par_type_q, par_type_d;
    logic [1:0]              samp_q, samp_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_acc_q, par_acc_d;
    logic                    par_err_q, par_err_d;
    logic [DATA_WIDTH-1:0]   rx_out_p_q, rx_out_p_d;
    logic                    rx_out_v_q, rx_out_v_d;
    logic                    perr_q, perr_d;
    logic                    ferr_q, ferr_d;
    logic                    line;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Idle-high synchronizer so reset release never looks like a start bit
    always_ff @(posedge RX_CLK or posedge RST) begin
        if (RST) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], bus.RX_IN_S};
    end
    assign line = sync_q[1];
`else
    assign line = bus.RX_IN_S;
`endif

    logic [EDGE_W-1:0] half;
    logic              last_edge, samp_a, samp_b, decide, bit_val;

    always_comb begin
        half      = {1'b0, presc_q[EDGE_W-1:1]};
        last_edge = (edge_q == presc_q - EDGE_W'(1));
        samp_a    = (edge_q == half - EDGE_W'(1));
        samp_b    = (edge_q == half);
        decide    = (edge_q == half + EDGE_W'(1));
        bit_val   = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        presc_d    = presc_q;
        bit_d      = bit_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        par_err_d  = par_err_q;
        rx_out_p_d = rx_out_p_q;
        rx_out_v_d = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;

        if (state_q != IDLE) begin
            edge_d = last_edge ? '0 : edge_q + EDGE_W'(1);
            if (samp_a) samp_d[0] = line;
            if (samp_b) samp_d[1] = line;
        end

        case (state_q)
            IDLE: begin
                edge_d = '0;
                if (!line) begin
                    // This cycle is edge 0 of the start bit
                    state_d    = START;
                    edge_d     = EDGE_W'(1);
                    presc_d    = bus.Prescale & 6'h3E;
                    par_en_d   = bus.parity_enable;
                    par_type_d = bus.parity_type;
                    bit_d      = '0;
                    par_acc_d  = 1'b0;
                    par_err_d  = 1'b0;
                end
            end
            START: begin
                if (decide && bit_val) begin
                    state_d = IDLE;
                    edge_d  = '0;
                end else if (last_edge) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    par_acc_d = par_acc_q ^ bit_val;
                end
                if (last_edge) begin
                    if (bit_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + BIT_CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (decide) par_err_d = ((par_acc_q ^ bit_val) != par_type_q);
                if (last_edge) state_d = STOP;
            end
            STOP: begin
                // Return to IDLE mid stop bit so a closely following start is caught
                if (decide) begin
                    state_d = IDLE;
                    edge_d  = '0;
                    perr_d  = par_err_q;
                    ferr_d  = !bit_val;
                    if (bit_val && !par_err_q) begin
                        rx_out_v_d = 1'b1;
                        rx_out_p_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                edge_d  = '0;
            end
        endcase
    end

    always_ff @(posedge RX_CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            presc_q    <= '0;
            bit_q      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            samp_q     <= '0;
            shift_q    <= '0;
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
            rx_out_p_q <= '0;
            rx_out_v_q <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            presc_q    <= presc_d;
            bit_q      <= bit_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            par_acc_q  <= par_acc_d;
            par_err_q  <= par_err_d;
            rx_out_p_q <= rx_out_p_d;
            rx_out_v_q <= rx_out_v_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign bus.RX_OUT_P      = rx_out_p_q;
    assign bus.RX_OUT_V      = rx_out_v_q;
    assign bus.parity_error  = perr_q;
    assign bus.framing_error = ferr_q;
endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: hand-built frames, pulse timing/data checked against fixed values.
module tb_uart_rx_deser;
    logic RX_CLK;
    logic RST;

    uart_rx_deser_if #(.DATA_WIDTH(8)) bus ();

    uart_rx_deser #(.DATA_WIDTH(8)) dut (
        .RX_CLK (RX_CLK),
        .RST    (RST),
        .bus    (bus)
    );

    initial RX_CLK = 1'b0;
    always #5 RX_CLK = ~RX_CLK;

    int cyc = 0;
    always @(posedge RX_CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;
    int v_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
    int v_cyc = 0, perr_cyc = 0, ferr_cyc = 0;
    logic [7:0] v_hist[$];

    // Pulse monitor, sampled mid-cycle
    always @(negedge RX_CLK) begin
        if (bus.RX_OUT_V) begin
            v_cnt++;
            v_cyc = cyc;
            v_hist.push_back(bus.RX_OUT_P);
        end
        if (bus.parity_error) begin
            perr_cnt++;
            perr_cyc = cyc;
        end
        if (bus.framing_error) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic val, input int p);
        bus.RX_IN_S = val;
        repeat (p) @(negedge RX_CLK);
    endtask

    // Called on a negedge; t0 is the cycle in which the line first goes low
    task automatic send_frame(input logic [7:0] data, input int p, input logic par_en,
                              input logic par_bit, input logic stop_bit, output int t0);
        t0 = cyc;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(data[i], p);
        if (par_en) drive_bit(par_bit, p);
        drive_bit(stop_bit, p);
        bus.RX_IN_S = 1'b1;
    endtask

    int t0, t1, v0, p0, f0;

    initial begin
        RST               = 1'b1;
        bus.RX_IN_S       = 1'b1;
        bus.Prescale      = 6'd8;
        bus.parity_enable = 1'b0;
        bus.parity_type   = 1'b0;
        repeat (3) @(negedge RX_CLK);
        check("rst_out_p",  32'(bus.RX_OUT_P), 32'h0);
        check("rst_out_v",  32'(bus.RX_OUT_V), 32'h0);
        check("rst_perr",   32'(bus.parity_error), 32'h0);
        check("rst_ferr",   32'(bus.framing_error), 32'h0);
        RST = 1'b0;
        repeat (4) @(negedge RX_CLK);

        // P=8, no parity, 0xA5 good frame
        v0 = v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, t0);
        repeat (4) @(negedge RX_CLK);
        check("a5_v_count", 32'(v_cnt - v0), 32'd1);
        check("a5_v_cycle", 32'(v_cyc - t0), 32'd78);
        check("a5_data",    32'(bus.RX_OUT_P), 32'hA5);
        check("a5_perr",    32'(perr_cnt - p0), 32'd0);
        check("a5_ferr",    32'(ferr_cnt - f0), 32'd0);

        // P=16, even parity, 0x3C with wrong parity bit 1
        bus.Prescale = 6'd16; bus.parity_enable = 1'b1; bus.parity_type = 1'b0;
        v0 = v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, t0);
        repeat (4) @(negedge RX_CLK);
        check("par_perr_count", 32'(perr_cnt - p0), 32'd1);
        check("par_perr_cycle", 32'(perr_cyc - t0), 32'd170);
        check("par_v_count",    32'(v_cnt - v0), 32'd0);
        check("par_data_held",  32'(bus.RX_OUT_P), 32'hA5);
        check("par_ferr",       32'(ferr_cnt - f0), 32'd0);

        // P=8, no parity, 0x81 with stop bit low
        bus.Prescale = 6'd8; bus.parity_enable = 1'b0;
        v0 = v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, t0);
        repeat (20) @(negedge RX_CLK);
        check("frm_ferr_count", 32'(ferr_cnt - f0), 32'd1);
        check("frm_ferr_cycle", 32'(ferr_cyc - t0), 32'd78);
        check("frm_v_count",    32'(v_cnt - v0), 32'd0);
        check("frm_perr",       32'(perr_cnt - p0), 32'd0);
        check("frm_data_held",  32'(bus.RX_OUT_P), 32'hA5);

        // P=16, 2-cycle glitch must be rejected silently
        bus.Prescale = 6'd16;
        v0 = v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        bus.RX_IN_S = 1'b0;
        repeat (2) @(negedge RX_CLK);
        bus.RX_IN_S = 1'b1;
        repeat (40) @(negedge RX_CLK);
        check("glitch_v",    32'(v_cnt - v0), 32'd0);
        check("glitch_perr", 32'(perr_cnt - p0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Reset during data bit 4 of a P=8 frame, then a clean 0x5A
        bus.Prescale = 6'd8;
        v0 = v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 8);
        drive_bit(1'b0, 3);
        RST = 1'b1;
        @(negedge RX_CLK);
        check("mid_rst_out_p", 32'(bus.RX_OUT_P), 32'h0);
        check("mid_rst_out_v", 32'(bus.RX_OUT_V), 32'h0);
        check("mid_rst_perr",  32'(bus.parity_error), 32'h0);
        check("mid_rst_ferr",  32'(bus.framing_error), 32'h0);
        bus.RX_IN_S = 1'b1;
        repeat (3) @(negedge RX_CLK);
        RST = 1'b0;
        repeat (4) @(negedge RX_CLK);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, t0);
        repeat (4) @(negedge RX_CLK);
        check("post_rst_v_count", 32'(v_cnt - v0), 32'd1);
        check("post_rst_v_cycle", 32'(v_cyc - t0), 32'd78);
        check("post_rst_data",    32'(bus.RX_OUT_P), 32'h5A);
        check("post_rst_errs",    32'((perr_cnt - p0) + (ferr_cnt - f0)), 32'd0);

        // P=32, odd parity, back-to-back 0xFF then 0x00 (parity bit 1 each)
        bus.Prescale = 6'd32; bus.parity_enable = 1'b1; bus.parity_type = 1'b1;
        v0 = v_cnt; p0 = perr_cnt; f0 = ferr_cnt;
        send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b1, t0);
        send_frame(8'h00, 32, 1'b1, 1'b1, 1'b1, t1);
        repeat (4) @(negedge RX_CLK);
        check("b2b_v_count",  32'(v_cnt - v0), 32'd2);
        check("b2b_first",    32'(v_hist[v_hist.size() - 2]), 32'hFF);
        check("b2b_second",   32'(v_hist[v_hist.size() - 1]), 32'h00);
        check("b2b_v_cycle",  32'(v_cyc - t1), 32'd338);
        check("b2b_perr",     32'(perr_cnt - p0), 32'd0);
        check("b2b_ferr",     32'(ferr_cnt - f0), 32'd0);
        check("b2b_out_p",    32'(bus.RX_OUT_P), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
